// File: rtl/demux1x64_seq.sv
// demux1x64_seq: registered 1-to-N demultiplexer with direct select or auto-counting lanes.
// In auto mode a full wrap of the counter holds the frame until frame_ack.
module demux1x64_seq #(
    parameter int N_CH  = 64,
    parameter int SEL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto_mode,
    output logic [N_CH-1:0]  out,
    output logic [N_CH-1:0]  out_strobe,
    output logic [SEL_W-1:0] cur_ch,
    output logic             frame_valid,
    input  logic             frame_ack
);
    typedef enum logic {FILL, FULL} state_t;
    state_t state;
    logic accept;
    logic [SEL_W-1:0] target;
    assign in_ready = (state == FILL) & ~clear;
    assign accept   = in_valid & in_ready;
    assign target   = auto_mode ? cur_ch : sel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            out         <= '0;
            out_strobe  <= '0;
            cur_ch      <= '0;
            frame_valid <= 1'b0;
        end else if (clear) begin
            state       <= FILL;
            out         <= '0;
            out_strobe  <= '0;
            cur_ch      <= '0;
            frame_valid <= 1'b0;
        end else begin
            out_strobe <= '0;
            if (accept) begin
                out[target] <= in_data;
                out_strobe  <= {{(N_CH-1){1'b0}}, 1'b1} << target;
                if (auto_mode) begin
                    cur_ch <= cur_ch + 1'b1;
                    // last lane of the frame: counter wraps and the bank is frozen
                    if (&cur_ch) begin
                        state       <= FULL;
                        frame_valid <= 1'b1;
                    end
                end
            end else if (state == FULL && frame_ack) begin
                state       <= FILL;
                frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demux1x64_seq.sv
// tb_demux1x64_seq: directed checks of lane routing, frame hold/ack, clear and async reset.
module tb_demux1x64_seq;
    logic        clk = 0;
    logic        rst = 0;
    logic        clear = 0;
    logic        in_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [5:0]  sel = 0;
    logic        auto_mode = 0;
    logic [63:0] out;
    logic [63:0] out_strobe;
    logic [5:0]  cur_ch;
    logic        frame_valid;
    logic        frame_ack = 0;
    int n = 0;
    int errs = 0;
    logic [63:0] exp_out;

    demux1x64_seq dut (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .auto_mode(auto_mode), .out(out),
        .out_strobe(out_strobe), .cur_ch(cur_ch), .frame_valid(frame_valid),
        .frame_ack(frame_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_out", out, 64'd0);
        chk("rst_strobe", out_strobe, 64'd0);
        chk("rst_cur_ch", 64'(cur_ch), 64'd0);
        chk("rst_fv", 64'(frame_valid), 64'd0);
        step();
        rst = 0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        // direct write to lane 37
        sel = 6'd37; in_data = 1; in_valid = 1;
        step();
        in_valid = 0;
        chk("dir_out", out, 64'd1 << 37);
        chk("dir_strobe", out_strobe, 64'd1 << 37);
        chk("dir_cur_ch", 64'(cur_ch), 64'd0);
        chk("dir_fv", 64'(frame_valid), 64'd0);
        step();
        chk("idle_strobe", out_strobe, 64'd0);
        // full auto frame with alternating data
        auto_mode = 1; in_valid = 1;
        for (int i = 0; i < 64; i++) begin
            in_data = i[0];
            step();
            if (i == 62) chk("fv_before_last", 64'(frame_valid), 64'd0);
        end
        chk("frame_out", out, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("frame_strobe", out_strobe, 64'd1 << 63);
        chk("frame_fv", 64'(frame_valid), 64'd1);
        chk("frame_cur_ch", 64'(cur_ch), 64'd0);
        chk("frame_ready", 64'(in_ready), 64'd0);
        // held while FULL
        in_data = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_strobe", out_strobe, 64'd0);
            chk("full_out", out, 64'hAAAA_AAAA_AAAA_AAAA);
        end
        in_valid = 0; frame_ack = 1;
        step();
        frame_ack = 0;
        chk("ack_ready", 64'(in_ready), 64'd1);
        chk("ack_fv", 64'(frame_valid), 64'd0);
        in_valid = 1; in_data = 1;
        step();
        chk("resume_strobe", out_strobe, 64'd1);
        chk("resume_out", out, 64'hAAAA_AAAA_AAAA_AAAB);
        chk("resume_cur_ch", 64'(cur_ch), 64'd1);
        // advance to lane 20 then clear with a sample pending
        for (int i = 0; i < 19; i++) step();
        chk("pre_clear_ch", 64'(cur_ch), 64'd20);
        clear = 1;
        #1;
        chk("clear_ready", 64'(in_ready), 64'd0);
        step();
        clear = 0;
        chk("clear_out", out, 64'd0);
        chk("clear_strobe", out_strobe, 64'd0);
        chk("clear_cur_ch", 64'(cur_ch), 64'd0);
        chk("clear_fv", 64'(frame_valid), 64'd0);
        step();
        chk("post_clear_strobe", out_strobe, 64'd1);
        chk("post_clear_out", out, 64'd1);
        in_valid = 0; clear = 1;
        step();
        clear = 0;
        // partial frame interrupted by a direct write
        in_valid = 1; in_data = 1;
        for (int i = 0; i < 10; i++) step();
        chk("part_out", out, 64'h3FF);
        chk("part_cur_ch", 64'(cur_ch), 64'd10);
        auto_mode = 0; sel = 6'd5; in_data = 0;
        step();
        chk("mix_dir_out", out, 64'h3DF);
        chk("mix_dir_strobe", out_strobe, 64'd1 << 5);
        chk("mix_dir_cur_ch", 64'(cur_ch), 64'd10);
        auto_mode = 1; in_data = 1;
        for (int i = 0; i < 54; i++) begin
            step();
            if (i == 0) chk("mix_resume_strobe", out_strobe, 64'd1 << 10);
            if (i == 52) chk("mix_fv_early", 64'(frame_valid), 64'd0);
        end
        exp_out = ~(64'd1 << 5);
        chk("mix_out", out, exp_out);
        chk("mix_fv", 64'(frame_valid), 64'd1);
        chk("mix_cur_ch", 64'(cur_ch), 64'd0);
        // async reset mid-frame
        in_valid = 0; frame_ack = 1;
        step();
        frame_ack = 0; in_valid = 1;
        for (int i = 0; i < 40; i++) step();
        chk("pre_rst_ch", 64'(cur_ch), 64'd40);
        chk("pre_rst_strobe", out_strobe, 64'd1 << 39);
        #2 rst = 1;
        #1;
        chk("arst_out", out, 64'd0);
        chk("arst_strobe", out_strobe, 64'd0);
        chk("arst_cur_ch", 64'(cur_ch), 64'd0);
        chk("arst_fv", 64'(frame_valid), 64'd0);
        in_valid = 0;
        step();
        rst = 0;
        #1;
        chk("arst_ready", 64'(in_ready), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/demux1x64_seq.md
Name: demux1x64_seq

Overview:
- Registered 1-to-64 demultiplexer: the distribution-side counterpart to the team's 64:1 selector.
- Routes a single-bit input sample to one of 64 output bit registers. The lane comes from an external select (direct mode) or an internal wrapping channel counter (auto mode).
- In auto mode, 64 consecutive accepted samples form a frame. The frame is held until the consumer acknowledges it.
- Sits between a serial source and wide parallel consumers, e.g. as the loader for a mux64x1 input bank.

Parameters:
- N_CH, 64, number of output lanes (power of two; only 64 is verified).
- SEL_W, 6, select/counter width, equal to log2(N_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of counter, frame state and output bank.
- in_data  input  1  sample to distribute.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample this cycle.
- sel  input  SEL_W  target lane in direct mode.
- auto_mode  input  1  1 = lane from internal counter; 0 = lane from sel.
- out  output  N_CH  registered output bank; bit i holds the last sample written to lane i.
- out_strobe  output  N_CH  one-hot, one-cycle pulse marking the lane written.
- cur_ch  output  SEL_W  current internal counter value.
- frame_valid  output  1  auto-mode frame of 64 samples complete and held.
- frame_ack  input  1  consumer has taken the frame.

Behaviour:
- Reset (rst=1, asynchronous): out=0, out_strobe=0, cur_ch=0, frame_valid=0, state=FILL. in_ready=1 once rst and clear are low.
- States: FILL (accepting samples), FULL (auto frame held).
- in_ready = (state==FILL) & ~clear. This is combinational, with no dependence on in_valid.
- accept = in_valid & in_ready.
- target = auto_mode ? cur_ch : sel. It is sampled in the accept cycle.
- On accept, at the next edge:
  - out[target] <= in_data; all other out bits hold.
  - out_strobe <= one-hot(target).
- Without accept, out_strobe <= 0. Write latency is 1 cycle from accept to out/out_strobe.
- Auto mode, on accept:
  - cur_ch <= cur_ch+1, modulo 64.
  - If cur_ch==63: cur_ch wraps to 0, state <= FULL, frame_valid <= 1 (same edge that writes out[63]).
- Direct mode: cur_ch holds; the state never enters FULL from a direct write.
- FULL:
  - in_ready=0; out bank is stable.
  - frame_ack=1 -> state <= FILL and frame_valid <= 0 at the next edge; accepts resume the cycle after.
  - FULL persists across auto_mode changes until frame_ack or clear.
- frame_ack in FILL is ignored.
- Mode switch in FILL does not reset cur_ch. A partial frame resumes where it left off when auto_mode returns to 1.
- clear=1 (synchronous, priority over all except rst):
  - cur_ch <= 0, state <= FILL, frame_valid <= 0, out <= 0, out_strobe <= 0.
  - in_ready is low during clear, so no sample is accepted in that cycle.
- Back-to-back: accepts can occur every cycle in FILL. 64 consecutive auto accepts produce frame_valid 1 cycle after the 64th accept.
- sel is don't-care when auto_mode=1; in_data and sel are don't-care when accept=0.
- Async reset mid-frame: all state is dropped immediately; the partial frame is lost.

Test Plan:
- Reset, then direct mode: sel=37, in_data=1, in_valid=1 for 1 cycle -> next cycle out[37]=1, out_strobe=1<<37, other out bits 0, cur_ch=0, frame_valid=0.
- Auto mode, 64 back-to-back accepts with in_data = ch[0] (0,1,0,1...) -> out=64'hAAAA_AAAA_AAAA_AAAA.
  - frame_valid rises 1 cycle after the 64th accept; cur_ch=0; in_ready=0 from then.
- While FULL, in_valid=1 for 5 cycles, then frame_ack=1 for 1 cycle:
  - No strobes and out unchanged during FULL.
  - in_ready=1 and frame_valid=0 the cycle after ack; the next sample lands in lane 0.
- Auto mode: 10 accepts, then auto_mode=0 for a direct write to sel=5, then auto_mode=1 for 54 accepts:
  - The direct write hits lane 5 only.
  - The auto sequence resumes at lane 10; frame_valid after the 54th auto accept.
- Auto mode at cur_ch=20 with in_valid=1, clear=1 for 1 cycle:
  - in_ready=0 in the clear cycle, no strobe.
  - Next cycle: out=0, cur_ch=0, frame_valid=0; the following accept writes lane 0.
- Assert rst asynchronously mid-cycle at cur_ch=40 in FILL -> all outputs 0 immediately without waiting for a clk edge; in_ready=1 after rst deasserts.
